// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single data-memory port between the two memory-stage lanes of
// a dual-issue pipeline. Each bundle's memory ops go out one at a time, lane 0 before lane 1.
// The pipeline is held via stall until every op has been acknowledged. Per-lane load data is
// then presented for one done cycle.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   lane_valid/we/addr/      per-lane memory op of the current bundle
//   wdata/be                 (held stable by the pipeline while stall=1)
//   flush                    cancel ops of the bundle that have not been issued yet
//   stall                    freeze ex_to_mem and mem_to_cmt
//   done                     one-cycle pulse when the bundle completes
//   lane_rdata               per-lane load data, valid while done=1, held until next done
//   bus_err                  sticky memory-timeout flag
//   mem_req/we/addr/wdata/be request to the memory port
//   mem_ack, mem_rdata       memory acknowledge and load data
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              lane_valid,
    input  logic [1:0]              lane_we,
    input  logic [2*ADDR_W-1:0]     lane_addr,
    input  logic [2*DATA_W-1:0]     lane_wdata,
    input  logic [2*(DATA_W/8)-1:0] lane_be,
    input  logic                    flush,
    output logic                    stall,
    output logic                    done,
    output logic [2*DATA_W-1:0]     lane_rdata,
    output logic                    bus_err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [DATA_W/8-1:0]     mem_be,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e               state_q, state_d;
    logic                 cur_q;
    logic [1:0]           served_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 flush_q;
    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic [BE_W-1:0]      mem_be_q;
    logic [2*DATA_W-1:0]  buf_q, buf_d;
    logic [2*DATA_W-1:0]  lane_rdata_q;
    logic                 bus_err_q;

    logic                 start;
    logic                 start_lane;
    logic                 sel;
    logic                 timeout;
    logic                 op_done;
    logic                 next_lane1;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [BE_W-1:0]      sel_be;

    // A flush that arrives while the bundle is still idle cancels it outright.
    assign start      = (|lane_valid) && !flush;
    assign start_lane = lane_valid[0] ? 1'b0 : 1'b1;

    // Timeout is a forced completion: the op finishes as if acked with zero data.
    assign timeout    = (cnt_q == CNT_W'(WAIT_MAX)) && !mem_ack;
    assign op_done    = mem_ack || timeout;

    // Flush is remembered so a short pulse during the outstanding op still skips lane 1.
    assign next_lane1 = !cur_q && lane_valid[1] && !served_q[1] && !flush && !flush_q;

    // Lane whose fields get loaded into the request registers on this edge.
    assign sel       = (state_q == StIdle) ? start_lane : 1'b1;
    assign sel_we    = sel ? lane_we[1] : lane_we[0];
    assign sel_addr  = sel ? lane_addr[2*ADDR_W-1:ADDR_W] : lane_addr[ADDR_W-1:0];
    assign sel_wdata = sel ? lane_wdata[2*DATA_W-1:DATA_W] : lane_wdata[DATA_W-1:0];
    assign sel_be    = sel ? lane_be[2*BE_W-1:BE_W] : lane_be[BE_W-1:0];

    // Capture buffer: cleared at bundle start, so skipped, store and timed-out lanes read 0.
    always_comb begin
        buf_d = buf_q;
        if (state_q == StIssue && mem_ack && !mem_we_q) begin
            if (cur_q) buf_d[2*DATA_W-1:DATA_W] = mem_rdata;
            else       buf_d[DATA_W-1:0]        = mem_rdata;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StIssue;
            StIssue: if (op_done && !next_lane1) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q        <= 1'b0;
            served_q     <= 2'b00;
            cnt_q        <= '0;
            flush_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            buf_q        <= '0;
            lane_rdata_q <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cur_q       <= start_lane;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        mem_be_q    <= sel_be;
                        cnt_q       <= '0;
                        flush_q     <= 1'b0;
                        buf_q       <= '0;
                    end
                end
                StIssue: begin
                    if (flush) flush_q <= 1'b1;
                    if (op_done) begin
                        served_q[cur_q] <= 1'b1;
                        cnt_q           <= '0;
                        buf_q           <= buf_d;
                        if (timeout) bus_err_q <= 1'b1;
                        if (next_lane1) begin
                            // Back-to-back: mem_req stays high, only the fields change.
                            cur_q       <= 1'b1;
                            mem_we_q    <= sel_we;
                            mem_addr_q  <= sel_addr;
                            mem_wdata_q <= sel_wdata;
                            mem_be_q    <= sel_be;
                        end else begin
                            mem_req_q    <= 1'b0;
                            lane_rdata_q <= buf_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    served_q <= 2'b00;
                    flush_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Outputs. stall is gated by rst so it drops the moment reset asserts.
    always_comb begin
        stall      = rst && (state_q != StDone) && (state_q != StIdle || start);
        done       = (state_q == StDone);
        lane_rdata = lane_rdata_q;
        bus_err    = bus_err_q;
        mem_req    = mem_req_q;
        mem_we     = mem_we_q;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
        mem_be     = mem_be_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table-driven bench for mem_port_arbiter (WAIT_MAX=4), with a
// small memory responder of programmable ack latency and hand-written timeout, flush and
// asynchronous-reset sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  lane_valid;
    logic [1:0]  lane_we;
    logic [63:0] lane_addr;
    logic [63:0] lane_wdata;
    logic [7:0]  lane_be;
    logic        flush;
    logic        stall;
    logic        done;
    logic [63:0] lane_rdata;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .WAIT_MAX(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lane_valid(lane_valid),
        .lane_we   (lane_we),
        .lane_addr (lane_addr),
        .lane_wdata(lane_wdata),
        .lane_be   (lane_be),
        .flush     (flush),
        .stall     (stall),
        .done      (done),
        .lane_rdata(lane_rdata),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after resp_lat wait cycles, logs accepted addresses.
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] ack_log [$];
    int          resp_lat = 0;
    int          wcnt = 0;

    always @(negedge clk) begin
        mem_ack   = mem_req && (wcnt >= resp_lat);
        mem_rdata = 32'h0;
        if (mem_ack && !mem_we && mem_model.exists(mem_addr)) mem_rdata = mem_model[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_req && mem_ack) begin
            ack_log.push_back(mem_addr);
            if (mem_we) mem_model[mem_addr] = mem_wdata;
        end
        if (mem_req && !mem_ack) wcnt = wcnt + 1;
        else                     wcnt = 0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [31:0] a0, a1, w0, w1;
        int          lat;
        logic [31:0] r0, r1;
        int          cycles;
        int          reqs;
        int          acks;
    } vec_t;

    // Drives one bundle (entered just after a rising edge) and checks its whole life cycle.
    task automatic run_bundle(input vec_t v, input int flush_at);
        int cyc = 0;
        int reqs = 0;
        int stall_bad = 0;
        bit got_done = 0;
        ack_log.delete();
        resp_lat   = v.lat;
        lane_valid = v.valid;
        lane_we    = v.we;
        lane_addr  = {v.a1, v.a0};
        lane_wdata = {v.w1, v.w0};
        lane_be    = 8'hFF;
        while (!got_done && cyc < 100) begin
            flush = (cyc == flush_at);
            @(negedge clk);
            if (mem_req) reqs++;
            if (done) begin
                got_done = 1;
                chk({v.name, ".rdata0"}, {32'h0, lane_rdata[31:0]}, {32'h0, v.r0});
                chk({v.name, ".rdata1"}, {32'h0, lane_rdata[63:32]}, {32'h0, v.r1});
                chk({v.name, ".stall_at_done"}, {63'h0, stall}, 64'h0);
            end else if (!stall) begin
                stall_bad++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        lane_valid = 2'b00;
        flush      = 1'b0;
        chk({v.name, ".got_done"}, {63'h0, got_done}, 64'h1);
        chk({v.name, ".cycles"}, 64'(cyc), 64'(v.cycles));
        chk({v.name, ".req_cycles"}, 64'(reqs), 64'(v.reqs));
        chk({v.name, ".stall_gaps"}, 64'(stall_bad), 64'h0);
        chk({v.name, ".acks"}, 64'(ack_log.size()), 64'(v.acks));
        if (v.acks > 0)
            chk({v.name, ".first_addr"}, {32'h0, ack_log[0]},
                {32'h0, (v.valid[0] ? v.a0 : v.a1)});
        @(negedge clk);
        chk({v.name, ".done_one_cycle"}, {62'h0, done, stall}, 64'h0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[6];
    vec_t tv;
    int   idle_bad;

    initial begin
        // name, valid, we, a0, a1, w0, w1, lat, r0, r1, cycles, req cycles, acks
        vecs[0] = '{"single_load", 2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 2,
                    32'hDEADBEEF, 32'h0, 5, 3, 1};
        vecs[1] = '{"st_ld_zero_lat", 2'b11, 2'b01, 32'h200, 32'h200, 32'h11223344, 32'h0, 0,
                    32'h0, 32'h11223344, 4, 2, 2};
        vecs[2] = '{"lane1_only", 2'b10, 2'b00, 32'h0, 32'h300, 32'h0, 32'h0, 1,
                    32'h0, 32'hCAFEF00D, 4, 2, 1};
        vecs[3] = '{"dual_load", 2'b11, 2'b00, 32'h100, 32'h300, 32'h0, 32'h0, 1,
                    32'hDEADBEEF, 32'hCAFEF00D, 6, 4, 2};
        vecs[4] = '{"ld_st_lat2", 2'b11, 2'b10, 32'h200, 32'h400, 32'h0, 32'h55AA55AA, 2,
                    32'h11223344, 32'h0, 8, 6, 2};
        vecs[5] = '{"readback", 2'b01, 2'b00, 32'h400, 32'h0, 32'h0, 32'h0, 0,
                    32'h55AA55AA, 32'h0, 3, 1, 1};

        mem_model[32'h100] = 32'hDEADBEEF;
        mem_model[32'h300] = 32'hCAFEF00D;

        rst        = 1'b0;
        lane_valid = 2'b00;
        lane_we    = 2'b00;
        lane_addr  = '0;
        lane_wdata = '0;
        lane_be    = '0;
        flush      = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset.outputs", {58'h0, stall, done, bus_err, mem_req, 2'b00}, 64'h0);
        chk("reset.lane_rdata", lane_rdata, 64'h0);

        for (int i = 0; i < 6; i++) run_bundle(vecs[i], -1);

        // Empty bundle: nothing happens.
        idle_bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (stall || mem_req || done) idle_bad++;
            @(posedge clk);
            #1;
        end
        chk("empty.idle", 64'(idle_bad), 64'h0);
        chk("bus_err.clean", {63'h0, bus_err}, 64'h0);

        // Timeout: 4 wait cycles, forced completion in the 5th request cycle.
        tv = '{"timeout", 2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 1000,
               32'h0, 32'h0, 7, 5, 0};
        run_bundle(tv, -1);
        chk("timeout.bus_err", {63'h0, bus_err}, 64'h1);
        run_bundle(vecs[0], -1);
        chk("bus_err.sticky", {63'h0, bus_err}, 64'h1);

        // Flush while lane 0 is outstanding: lane 1 is never requested.
        tv = '{"flush", 2'b11, 2'b00, 32'h100, 32'h300, 32'h0, 32'h0, 3,
               32'hDEADBEEF, 32'h0, 6, 4, 1};
        run_bundle(tv, 2);

        // Asynchronous reset mid-request.
        resp_lat   = 3;
        lane_valid = 2'b11;
        lane_we    = 2'b00;
        lane_addr  = {32'h300, 32'h100};
        repeat (2) @(posedge clk);
        #1;
        chk("arst.pre_req", {63'h0, mem_req}, 64'h1);
        #2 rst = 1'b0;
        #1;
        chk("arst.mem_req", {63'h0, mem_req}, 64'h0);
        chk("arst.stall", {63'h0, stall}, 64'h0);
        chk("arst.done", {63'h0, done}, 64'h0);
        lane_valid = 2'b00;
        @(posedge clk);
        #3 rst = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (stall || mem_req || done) idle_bad++;
            @(posedge clk);
            #1;
        end
        chk("arst.idle_after", 64'(idle_bad), 64'h0);
        chk("arst.bus_err_cleared", {63'h0, bus_err}, 64'h0);
        chk("arst.lane_rdata", lane_rdata, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
